ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative 32-bit divider for the EX stage that executes DIV/DIVU operations. It takes operands from the EX-stage decode of the values latched by the ID/EX pipeline register and returns a 64-bit {remainder, quotient} pair for the HI/LO write path. While a division is in flight it raises a stall request toward the pipeline stall controller. That controller holds ID/EX and everything upstream until the result is ready.

## Interface

Parameters: none. Width is fixed at 32 bits, per the `RegisterBus` convention.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clock
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- op_a  in  32  dividend
- op_b  in  32  divisor
- start  in  1  division requested; EX holds it high until ready is seen
- annul  in  1  cancel the in-flight division (branch/flush); 1 = cancel
- result  out  64  [63:32] remainder (HI), [31:0] quotient (LO)
- ready  out  1  result valid
- stall_request  out  1  request to freeze EX and upstream stages

## Operation

FSM states are IDLE, BY_ZERO, ON and END.

- **IDLE**
  - If start=1, annul=0 and op_b=0: go to BY_ZERO.
  - If start=1, annul=0 and op_b≠0: go to ON. Latch |op_a| and |op_b| (magnitudes only when signed_div=1, raw otherwise). Latch signed_div, op_a[31] and op_b[31]. Clear counter (6 bits). Load dividend register (65 bits) = {32'b0, |op_a|, 1'b0}.
  - Otherwise stay in IDLE.
- **ON**
  - If annul=1: go to IDLE with result=0 and ready=0.
  - Else, while counter≠32: compute diff = dividend[64:32] − {1'b0, |op_b|}.
    - If diff is negative: dividend ← dividend<<1.
    - Otherwise: dividend ← {diff[31:0], dividend[31:0], 1'b1}.
    - Then counter++.
  - Else (counter=32), finalize:
    - quotient = dividend[31:0].
    - remainder = dividend[64:33].
    - Negate the quotient if signed_div and op_a[31]^op_b[31].
    - Negate the remainder if signed_div and op_a[31].
    - Register the result and go to END.
- **BY_ZERO**: result ← 0, go to END.
- **END**
  - ready=1 and result is held stable.
  - When start=0: go to IDLE, ready ← 0, result ← 0.
  - annul is ignored in END.
- **Arithmetic**: all arithmetic is modulo 2^32.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap.
- **stall_request** is combinational: start & ~annul & (state≠END).

## Timing

- **Reset**: state=IDLE, result=0, ready=0, counter=0, dividend=0.
  - Reset overrides everything, including mid-division. There is no residual ready after reset.
- **Normal latency**: start is first sampled at edge E0 (IDLE→ON).
  - Iterations occur at edges E0+1 … E0+32.
  - Finalize and transition to END at E0+33.
  - ready=1 is visible after E0+33.
- **Divide-by-zero**: ready is visible after edge E0+1.
- **Hold**: ready stays high while start=1. It drops one edge after start falls.
- **Back-to-back**: after END→IDLE, a new division cannot begin until the next edge. The minimum gap between ready pulses is therefore 2 cycles plus the division latency.
- **annul during ON**: takes effect at the next edge, and stall_request drops combinationally in the same cycle.
  - annul and start both high in IDLE: no operation is started.
- **Operand stability**: operands are sampled only on the IDLE→ON/BY_ZERO edge. Later changes to op_a, op_b or signed_div are ignored.

## Structure

- Add to the shared defines header:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivStart / DivStop;
  - DivResultReady / DivResultNotReady.
- The unit is a single module with no sub-modules. The EX stage instantiates it, and the stall controller ORs stall_request into the stop_all generation.

## Test plan

- **Unsigned divide**: DIVU 100 / 7 → result[31:0]=14, result[63:32]=2. ready rises exactly 33 edges after the start edge, and stall_request is high throughout.
- **Signed divide**: DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- **Divide by zero**: op_b=0, start=1 → ready after 1 edge, result=0. Dropping start then gives ready=0 on the next edge.
- **Annul**: annul pulsed at iteration 10 → IDLE on the next edge, stall_request=0, ready never asserts. A new start afterwards still completes correctly.
- **Reset mid-operation**: reset at iteration 20 → all outputs 0 and state IDLE. A re-issued DIVU 0xFFFFFFFF / 1 gives quotient 0xFFFFFFFF, remainder 0.
- **Overflow case**: DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Operands changed mid-division have no effect on the result.

Source files
------------

// File: rtl/ex_div_unit_pkg.sv
// rtl/ex_div_unit_pkg.sv - shared encodings and helpers for the EX-stage divider
//
// Holds the divider FSM state encodings, the start/stop and result-ready
// levels used on the handshake, and the operand magnitude helper.
// No ports (package).

package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DivIterations = 6'd32;

  // Two's complement magnitude when the operand is treated as signed.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - EX stage to divider handshake bundle
//
// Groups the operand, control and result signals between the EX stage
// (master) and the divider (slave).
//   signed_div, op_a, op_b, start, annul : EX stage -> divider
//   result, ready, stall_request         : divider -> EX stage / stall control

interface ex_div_unit_if;
  logic        signed_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_request;

  modport master (
    output signed_div, op_a, op_b, start, annul,
    input  result, ready, stall_request
  );

  modport slave (
    input  signed_div, op_a, op_b, start, annul,
    output result, ready, stall_request
  );
endinterface

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative 32-bit DIV/DIVU unit for the EX stage
//
// Restoring shift/subtract divider, one quotient bit per clock. Returns
// {remainder, quotient} and holds ready until start is dropped; requests a
// pipeline stall while a division is pending.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of ex_div_unit_if (operands, start/annul, result,
//           ready, stall_request)

module ex_div_unit (
  input  logic         clock,
  input  logic         reset,
  ex_div_unit_if.slave bus
);
  import ex_div_unit_pkg::*;

  div_state_t  state, state_next;
  logic [5:0]  counter, counter_next;
  logic [64:0] dividend, dividend_next;
  logic [31:0] mag_b, mag_b_next;
  logic        sdiv, sdiv_next;
  logic        sign_a, sign_a_next;
  logic        sign_b, sign_b_next;
  logic [63:0] result_q, result_next;
  logic        ready_q, ready_next;

  logic [32:0] diff;
  logic [31:0] quotient_fixed;
  logic [31:0] remainder_fixed;

  // dividend[64:33] is the running remainder, dividend[32] the next dividend
  // bit brought down; a set diff[32] means the trial subtraction underflowed.
  assign diff = dividend[64:32] - {1'b0, mag_b};

  // Quotient sign follows the operand signs, remainder sign follows the dividend.
  assign quotient_fixed  = (sdiv && (sign_a ^ sign_b)) ? (32'd0 - dividend[31:0]) : dividend[31:0];
  assign remainder_fixed = (sdiv && sign_a) ? (32'd0 - dividend[64:33]) : dividend[64:33];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DivFree;
      counter  <= 6'd0;
      dividend <= 65'd0;
      mag_b    <= 32'd0;
      sdiv     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= DivResultNotReady;
    end else begin
      state    <= state_next;
      counter  <= counter_next;
      dividend <= dividend_next;
      mag_b    <= mag_b_next;
      sdiv     <= sdiv_next;
      sign_a   <= sign_a_next;
      sign_b   <= sign_b_next;
      result_q <= result_next;
      ready_q  <= ready_next;
    end
  end

  always_comb begin
    state_next    = state;
    counter_next  = counter;
    dividend_next = dividend;
    mag_b_next    = mag_b;
    sdiv_next     = sdiv;
    sign_a_next   = sign_a;
    sign_b_next   = sign_b;
    result_next   = result_q;
    ready_next    = ready_q;

    case (state)
      DivFree: begin
        if (bus.start == DivStart && !bus.annul) begin
          if (bus.op_b == 32'd0) begin
            state_next = DivByZero;
          end else begin
            state_next    = DivOn;
            counter_next  = 6'd0;
            dividend_next = {32'd0, magnitude(bus.op_a, bus.signed_div), 1'b0};
            mag_b_next    = magnitude(bus.op_b, bus.signed_div);
            sdiv_next     = bus.signed_div;
            sign_a_next   = bus.op_a[31];
            sign_b_next   = bus.op_b[31];
          end
        end
      end

      DivByZero: begin
        result_next = 64'd0;
        ready_next  = DivResultReady;
        state_next  = DivEnd;
      end

      DivOn: begin
        if (bus.annul) begin
          state_next  = DivFree;
          result_next = 64'd0;
          ready_next  = DivResultNotReady;
        end else if (counter != DivIterations) begin
          if (diff[32]) begin
            dividend_next = {dividend[63:0], 1'b0};
          end else begin
            dividend_next = {diff[31:0], dividend[31:0], 1'b1};
          end
          counter_next = counter + 6'd1;
        end else begin
          result_next = {remainder_fixed, quotient_fixed};
          ready_next  = DivResultReady;
          state_next  = DivEnd;
        end
      end

      DivEnd: begin
        // Result is held until EX drops start; annul has no effect here.
        if (bus.start == DivStop) begin
          state_next  = DivFree;
          result_next = 64'd0;
          ready_next  = DivResultNotReady;
        end
      end

      default: state_next = DivFree;
    endcase
  end

  assign bus.result        = result_q;
  assign bus.ready         = ready_q;
  assign bus.stall_request = bus.start & ~bus.annul & (state != DivEnd);

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - self-checking bench for ex_div_unit

module tb_ex_div_unit;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ex_div_unit_if bus ();

  ex_div_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero for DIV.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit perturb, input int hold, input string tag);
    logic [63:0] exp;
    int cycles;
    int lat_exp;
    bit stall_ok;
    bit hold_ok;
    exp     = ref_div(s, a, b);
    lat_exp = (b == 32'd0) ? 2 : 34;
    bus.signed_div = s;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.annul = 1'b0;
    bus.start = 1'b1;
    stall_ok  = 1'b1;
    cycles    = 0;
    #1;
    if (bus.stall_request !== 1'b1) stall_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cycles++;
      if (bus.ready === 1'b1) break;
      if (bus.stall_request !== 1'b1) stall_ok = 1'b0;
      if (perturb) begin
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
      end
    end
    check({tag, "_latency"}, 64'(cycles), 64'(lat_exp));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_end"}, 64'(bus.stall_request), 64'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (bus.ready !== 1'b1 || bus.result !== exp) hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    bus.start = 1'b0;
    @(negedge clock);
    check({tag, "_drop_ready"}, 64'(bus.ready), 64'd0);
    check({tag, "_drop_result"}, bus.result, 64'd0);
  endtask

  task automatic expect_no_ready(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.ready !== 1'b0) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.signed_div = 1'b0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_stall", 64'(bus.stall_request), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_div(1'b0, 32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    check("divu_100_7_const", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, 0, "div_7_m2");
    run_div(1'b0, 32'd123, 32'd0, 1'b0, 2, "by_zero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "overflow");

    // Annul around iteration 10.
    bus.signed_div = 1'b0;
    bus.op_a  = 32'd5000;
    bus.op_b  = 32'd3;
    bus.start = 1'b1;
    repeat (11) @(negedge clock);
    bus.annul = 1'b1;
    #1;
    check("annul_stall_comb", 64'(bus.stall_request), 64'd0);
    @(negedge clock);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    check("annul_ready", 64'(bus.ready), 64'd0);
    check("annul_result", bus.result, 64'd0);
    expect_no_ready(40, "annul_never_ready");
    run_div(1'b0, 32'd5000, 32'd3, 1'b0, 0, "after_annul");

    // Reset around iteration 20.
    bus.op_a  = 32'd999;
    bus.op_b  = 32'd4;
    bus.start = 1'b1;
    repeat (21) @(negedge clock);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clock);
    check("midreset_ready", 64'(bus.ready), 64'd0);
    check("midreset_result", bus.result, 64'd0);
    check("midreset_stall", 64'(bus.stall_request), 64'd0);
    reset = 1'b0;
    expect_no_ready(40, "midreset_never_ready");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 0, "after_reset");

    // start and annul together in IDLE must not launch anything.
    bus.op_a  = 32'd77;
    bus.op_b  = 32'd5;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    #1;
    check("idle_annul_stall", 64'(bus.stall_request), 64'd0);
    @(negedge clock);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    expect_no_ready(40, "idle_annul_never_ready");

    for (int n = 0; n < 25; n++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_div(s, a, b, n[0], n % 3, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
